// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU: one 1-bit slice consumes operand bits LSB first,
// one per clock, and the result word plus flags are published on entry to DONE.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [2:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             slice_b;
  logic             slice_sum;
  logic             slice_cout;
  logic             slice_bit;
  logic [WIDTH-1:0] result;

  // The 1-bit slice; result is the full word as it would look after this edge's shift.
  always_comb begin
    slice_b    = b_sr[0] ^ (op[0] & ~op[2]);
    slice_sum  = a_sr[0] ^ slice_b ^ carry;
    slice_cout = (a_sr[0] & slice_b) | (carry & (a_sr[0] ^ slice_b));
    slice_bit  = slice_sum;
    if (op[2]) begin
      case (op[1:0])
        2'b00:   slice_bit = a_sr[0] & b_sr[0];
        2'b01:   slice_bit = a_sr[0] | b_sr[0];
        2'b10:   slice_bit = ~(a_sr[0] | b_sr[0]);
        default: slice_bit = a_sr[0] ^ b_sr[0];
      endcase
    end
    result = {slice_bit, res_sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sr  <= A;
            b_sr  <= B;
            op    <= control;
            cnt   <= '0;
            // Subtract starts with carry-in 1 to complete the two's complement of B.
            carry <= ~control[2] & control[0];
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= result[WIDTH-1:1];
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            out      <= result;
            carryout <= ~op[2] & slice_cout;
            overflow <= ~op[2] & (carry ^ slice_cout);
            zero     <= (result == '0);
            negative <= slice_bit;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed cases with hand-computed results,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alu_serial;

  localparam int W = 32;

  localparam logic [2:0] OP_ADD = 3'h2;
  localparam logic [2:0] OP_SUB = 3'h3;
  localparam logic [2:0] OP_AND = 3'h4;
  localparam logic [2:0] OP_OR  = 3'h5;
  localparam logic [2:0] OP_NOR = 3'h6;
  localparam logic [2:0] OP_XOR = 3'h7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   control = 3'h0;
  logic         busy, done, carryout, overflow, zero, negative;
  logic [W-1:0] out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;
  chk_t chk_q[$];

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .control(control),
    .busy(busy), .done(done), .out(out), .carryout(carryout),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  // Reference result as {out, carryout, overflow}, straight from word-level arithmetic.
  function automatic logic [W+1:0] model_op(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W:0]   sum;
    logic [W-1:0] bb;
    logic [W-1:0] r;
    logic         ovf;
    if (!op[2]) begin
      bb  = op[0] ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[0]};
      ovf = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
      return {sum[W-1:0], sum[W], ovf};
    end
    case (op[1:0])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~(a | b);
      default: r = a ^ b;
    endcase
    return {r, 2'b00};
  endfunction

  // Model: an accepted op publishes its precomputed result W edges after the accept edge.
  logic         m_busy, m_done, m_c, m_v, m_z, m_n;
  logic [W-1:0] m_out;
  logic [W+1:0] m_pend;
  int           remaining;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_out <= '0; m_c <= 1'b0; m_v <= 1'b0;
      m_z <= 1'b0; m_n <= 1'b0; m_pend <= '0; remaining <= 0;
    end else begin
      m_done <= 1'b0;
      if (remaining == 0) begin
        if (start) begin
          m_pend    <= model_op(control, A, B);
          remaining <= W;
          m_busy    <= 1'b1;
        end
      end else if (remaining == 1) begin
        remaining <= 0;
        m_busy    <= 1'b0;
        m_done    <= 1'b1;
        m_out     <= m_pend[W+1:2];
        m_c       <= m_pend[1];
        m_v       <= m_pend[0];
        m_z       <= (m_pend[W+1:2] == '0);
        m_n       <= m_pend[W+1];
      end else begin
        remaining <= remaining - 1;
      end
    end
  end

  // Single compare process: drains queued literal checks, then compares all outputs to the model.
  always @(negedge clk) begin : compare
    chk_t c;
    logic [W+5:0] act, exp;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      tests++;
      if (c.act !== c.exp) begin
        fails++;
        $display("[TB] FAIL %s: got %h, expected %h", c.name, c.act, c.exp);
      end
    end
    act = {busy, done, out, carryout, overflow, zero, negative};
    exp = {m_busy, m_done, m_out, m_c, m_v, m_z, m_n};
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20)
        $display("[TB] FAIL cycle_model t=%0t: got busy=%b done=%b out=%h c=%b v=%b z=%b n=%b, expected busy=%b done=%b out=%h c=%b v=%b z=%b n=%b",
                 $time, busy, done, out, carryout, overflow, zero, negative,
                 m_busy, m_done, m_out, m_c, m_v, m_z, m_n);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_q.push_back('{name: name, act: act, exp: exp});
  endtask

  // Pulse start for one cycle with the given operands, then scramble the inputs.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start   = 1'b1;
    control = op;
    A       = a;
    B       = b;
    @(negedge clk);
    start   = 1'b0;
    A       = $urandom;
    B       = $urandom;
    control = 3'($urandom);
  endtask

  task automatic waitDone(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = int'(busy);
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
    end
    if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int cyc, bcyc, dcount;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", 64'({busy, done, out, carryout, overflow, zero, negative}), 64'd0);

    checkOutput("model_add_ovf", 64'(model_op(OP_ADD, 32'h7FFF_FFFF, 32'h1)), 64'({32'h8000_0000, 2'b01}));
    checkOutput("model_sub_eq",  64'(model_op(OP_SUB, 32'd5, 32'd5)), 64'({32'h0, 2'b10}));
    checkOutput("model_or",      64'(model_op(OP_OR, 32'h1234_0000, 32'h0000_5678)), 64'({32'h1234_5678, 2'b00}));

    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    waitDone(cyc, bcyc);
    checkOutput("add_latency", 64'(cyc), 64'(W));
    checkOutput("add_busy_cycles", 64'(bcyc), 64'(W));
    checkOutput("add_out", 64'(out), 64'h8000_0000);
    checkOutput("add_flags_cvnz", 64'({carryout, overflow, negative, zero}), 64'b0110);

    applyStimulus(OP_SUB, 32'd5, 32'd5);
    waitDone(cyc, bcyc);
    checkOutput("sub_eq_out", 64'(out), 64'h0);
    checkOutput("sub_eq_flags_cvnz", 64'({carryout, overflow, negative, zero}), 64'b1001);

    applyStimulus(OP_SUB, 32'd0, 32'd1);
    waitDone(cyc, bcyc);
    checkOutput("sub_borrow_out", 64'(out), 64'hFFFF_FFFF);
    checkOutput("sub_borrow_flags_cvnz", 64'({carryout, overflow, negative, zero}), 64'b0010);

    applyStimulus(OP_NOR, 32'd0, 32'd0);
    waitDone(cyc, bcyc);
    checkOutput("nor_out", 64'(out), 64'hFFFF_FFFF);
    checkOutput("nor_flags_cvnz", 64'({carryout, overflow, negative, zero}), 64'b0010);

    applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
    waitDone(cyc, bcyc);
    checkOutput("xor_out", 64'(out), 64'h0F0F_F0F0);
    checkOutput("xor_flags_cvnz", 64'({carryout, overflow, negative, zero}), 64'b0000);

    applyStimulus(OP_ADD, 32'd100, 32'd23);
    repeat (5) @(negedge clk);
    start = 1'b1; A = 32'hDEAD_BEEF; B = 32'h1111_1111; control = OP_AND;
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitDone(cyc, bcyc);
    checkOutput("midrun_ignored_out", 64'(out), 64'd123);

    @(negedge clk);
    start = 1'b1; control = OP_AND; A = 32'hFF00_FF00; B = 32'h0FF0_0FF0;
    @(negedge clk);
    waitDone(cyc, bcyc);
    checkOutput("b2b_first_out", 64'(out), 64'h0F00_0F00);
    control = OP_OR; A = 32'h1234_0000; B = 32'h0000_5678;
    @(negedge clk);
    checkOutput("b2b_no_idle_busy_done", 64'({busy, done}), 64'b10);
    start = 1'b0;
    waitDone(cyc, bcyc);
    checkOutput("b2b_second_latency", 64'(cyc), 64'(W));
    checkOutput("b2b_second_out", 64'(out), 64'h1234_5678);

    applyStimulus(OP_SUB, 32'd1000, 32'd1);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("reset_async_clear", 64'({busy, done, out, carryout, overflow, zero, negative}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checkOutput("reset_no_done", 64'(dcount), 64'd0);
    applyStimulus(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
    waitDone(cyc, bcyc);
    checkOutput("after_reset_latency", 64'(cyc), 64'(W));
    checkOutput("after_reset_out", 64'(out), 64'h5555_5555);

    repeat (3000) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) != 0);
      A       = pick();
      B       = pick();
      control = 3'($urandom);
    end
    start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Multi-cycle, bit-serial WIDTH-bit ALU that drives a single 1-bit ALU slice, one bit per clock, LSB first.
- Upstream sequencer for the 1-bit slice: holds operand shift registers, a carry flip-flop and a bit counter, then assembles the result word and flags.
- Used where area matters more than latency. Sits between register-read and writeback in the lab datapath.
- Uses the team's standard op encoding: ADD=3'h2, SUB=3'h3, AND=3'h4, OR=3'h5, NOR=3'h6, XOR=3'h7.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- A  input  WIDTH  operand A. Captured on the accepting edge.
- B  input  WIDTH  operand B. Captured on the accepting edge.
- control  input  3  op code. Captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when a new result is valid.
- out  output  WIDTH  result register.
- carryout  output  1  final carry for arithmetic ops, 0 for logic ops.
- overflow  output  1  signed overflow for arithmetic ops, 0 for logic ops.
- zero  output  1  out == 0.
- negative  output  1  out[WIDTH-1].

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - busy=0, done=0, out=0, carryout=0, overflow=0, zero=0, negative=0.
  - Internal shift registers, carry flip-flop and counter cleared.
  - A reset mid-operation abandons the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 -> RUN.
    - Loads A and B shift regs and op reg.
    - cnt=0.
    - carry FF = control[0] when control[2]==0, else 0.
  - RUN:
    - Each edge consumes bit 0 of the shift regs through the slice.
    - The slice computes B' = B xor op[0] for arithmetic ops.
    - Sum or logic result is shifted into the MSB of the result shift reg.
    - carry FF <= slice carryout.
    - cnt++.
    - At the edge where cnt==WIDTH-1 (edge E_WIDTH) -> DONE; that same edge also updates out and all flags.
    - start is ignored in RUN. busy=1 throughout RUN.
  - DONE: done=1 for exactly this one cycle; busy=0.
    - Next edge -> RUN if start=1 (back-to-back accept with a fresh load), else -> IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 rising edges after the start edge, counting E0.
  - Throughput: one op per WIDTH+1 cycles with back-to-back starts.
- Result hold: out and flags change only on entry to DONE (or on reset); they hold through IDLE and RUN.
- Operand capture: changes on A, B or control after E0 have no effect on the current op.
- Flags:
  - Arithmetic ops (control[2]==0):
    - carryout = carry out of the MSB. SUB yields 1 when no borrow.
    - overflow = carry into MSB xor carry out of MSB.
  - Logic ops (control[2]==1): carryout=0, overflow=0.
  - zero and negative are derived from the final out value for every op.
- Codes 3'h0 and 3'h1 behave as ADD and SUB respectively (control[2]==0 selects arithmetic, control[0] selects invert/subtract).
- Logic ops: AND/OR/NOR/XOR select per control[1:0] = 00/01/10/11.

Test Plan:
- ADD, WIDTH=32, A=32'h7FFFFFFF, B=32'h1, start pulsed one cycle:
  - busy=1 for 32 cycles, done pulse exactly 33 edges after start.
  - out=32'h80000000, overflow=1, carryout=0, negative=1, zero=0.
- SUB, A=5, B=5 -> out=0, zero=1, carryout=1, overflow=0.
- SUB, A=0, B=1 -> out=32'hFFFFFFFF, carryout=0, negative=1, overflow=0.
- NOR, A=0, B=0 -> out=32'hFFFFFFFF, carryout=0, overflow=0.
- XOR, A=32'hF0F0F0F0, B=32'hFFFF0000 -> out=32'h0F0FF0F0.
- Control robustness:
  - start re-asserted and A changed mid-RUN -> ignored; result still reflects the original operands.
  - start held high through DONE -> second op accepted with no IDLE cycle.
  - reset asserted at cycle 10 of RUN -> all outputs 0 immediately, no done pulse; the next start runs normally.
